// File: rtl/dmem_ctrl.sv
// Dual-port (CPU + loader) data-memory controller: round-robin arbitration,
// big-endian byte/halfword lane handling, read-modify-write for sub-word stores.
module dmem_ctrl #(
  parameter int BITS_ADDR = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 a_req,
  input  logic                 a_we,
  input  logic [BITS_ADDR-1:0] a_addr,
  input  logic [1:0]           a_size,
  input  logic [31:0]          a_wdata,
  output logic                 a_gnt,
  output logic                 a_rvalid,
  output logic                 a_err,
  output logic [31:0]          a_rdata,
  input  logic                 b_req,
  input  logic                 b_we,
  input  logic [BITS_ADDR-1:0] b_addr,
  input  logic [31:0]          b_wdata,
  output logic                 b_gnt,
  output logic                 b_rvalid,
  output logic [31:0]          b_rdata,
  output logic [BITS_ADDR-3:0] mem_addr,
  output logic [31:0]          mem_wdata,
  output logic                 mem_we,
  input  logic [31:0]          mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, MERGE_WR, DONE} state_e;

  state_e               state_q, state_d;
  logic                 prio_b_q;
  logic                 port_b_q;
  logic                 we_q;
  logic                 err_q;
  logic [1:0]           size_q;
  logic [BITS_ADDR-1:0] addr_q;
  logic [31:0]          wdata_q;
  logic [31:0]          merged_q;
  logic [31:0]          a_rdata_q;
  logic [31:0]          b_rdata_q;

  logic        sel_a, sel_b, a_bad, word_wr;
  logic [4:0]  sh;
  logic [31:0] lo_mask, rd_ext, merged_d, result_d;

  // B wins a tie only when A was granted last.
  assign sel_a = a_req && (!b_req || !prio_b_q);
  assign sel_b = b_req && !sel_a;
  assign a_bad = (a_size == 2'b11) ||
                 ((a_size == 2'b01) && a_addr[0]) ||
                 ((a_size == 2'b10) && (a_addr[1:0] != 2'b00));
  assign word_wr = we_q && (size_q == 2'b10);

  // Lane position: byte offset k sits at bits [31-8k:24-8k].
  always_comb begin
    sh      = 5'd0;
    lo_mask = 32'hFFFF_FFFF;
    case (size_q)
      2'b00: begin
        lo_mask = 32'h0000_00FF;
        sh      = {2'd3 - addr_q[1:0], 3'b000};
      end
      2'b01: begin
        lo_mask = 32'h0000_FFFF;
        sh      = addr_q[1] ? 5'd0 : 5'd16;
      end
      default: ;
    endcase
    rd_ext   = (mem_rdata >> sh) & lo_mask;
    merged_d = (mem_rdata & ~(lo_mask << sh)) | ((wdata_q & lo_mask) << sh);
  end

  always_comb begin
    state_d  = state_q;
    result_d = 32'd0;
    case (state_q)
      IDLE: begin
        if (sel_a)      state_d = a_bad ? DONE : ACCESS;
        else if (sel_b) state_d = ACCESS;
      end
      ACCESS: begin
        state_d = (we_q && !word_wr) ? MERGE_WR : DONE;
        if (!we_q) result_d = rd_ext;
      end
      MERGE_WR: state_d = DONE;
      DONE:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      prio_b_q  <= 1'b0;
      port_b_q  <= 1'b0;
      we_q      <= 1'b0;
      err_q     <= 1'b0;
      size_q    <= 2'b00;
      addr_q    <= '0;
      wdata_q   <= 32'd0;
      merged_q  <= 32'd0;
      a_rdata_q <= 32'd0;
      b_rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && (sel_a || sel_b)) begin
        prio_b_q <= sel_a;
        port_b_q <= sel_b;
        we_q     <= sel_b ? b_we : a_we;
        err_q    <= sel_a && a_bad;
        size_q   <= sel_b ? 2'b10 : a_size;
        addr_q   <= sel_b ? b_addr : a_addr;
        wdata_q  <= sel_b ? b_wdata : a_wdata;
      end
      if (state_q == ACCESS) merged_q <= merged_d;
      // Read data is loaded on entry to DONE so it changes together with rvalid.
      if (state_d == DONE && state_q != DONE) begin
        if (state_q != IDLE && port_b_q) b_rdata_q <= result_d;
        else                             a_rdata_q <= result_d;
      end
    end
  end

  assign a_gnt     = rst_n && (state_q == IDLE) && sel_a;
  assign b_gnt     = rst_n && (state_q == IDLE) && sel_b;
  assign a_rvalid  = (state_q == DONE) && !port_b_q;
  assign b_rvalid  = (state_q == DONE) && port_b_q;
  assign a_err     = (state_q == DONE) && !port_b_q && err_q;
  assign a_rdata   = a_rdata_q;
  assign b_rdata   = b_rdata_q;
  assign mem_addr  = (state_q == ACCESS || state_q == MERGE_WR) ? addr_q[BITS_ADDR-1:2] : '0;
  assign mem_we    = ((state_q == ACCESS) && word_wr) || (state_q == MERGE_WR);
  assign mem_wdata = (state_q == MERGE_WR) ? merged_q :
                     ((state_q == ACCESS) && word_wr) ? wdata_q : 32'd0;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Scoreboard bench for dmem_ctrl: directed transactions push expectations,
// a negedge monitor pops and compares on every rvalid.
module tb_dmem_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        a_req = 0, a_we = 0;
  logic [7:0]  a_addr = 0;
  logic [1:0]  a_size = 0;
  logic [31:0] a_wdata = 0;
  logic        a_gnt, a_rvalid, a_err;
  logic [31:0] a_rdata;
  logic        b_req = 0, b_we = 0;
  logic [7:0]  b_addr = 0;
  logic [31:0] b_wdata = 0;
  logic        b_gnt, b_rvalid;
  logic [31:0] b_rdata;
  logic [5:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic        mem_we;

  logic [31:0] mem [64] = '{default: 32'd0};

  typedef struct {
    logic [31:0] rd;
    logic        err;
    int          lat;
  } exp_t;

  exp_t a_exp[$];
  exp_t b_exp[$];
  int   a_gcyc[$];
  int   b_gcyc[$];
  logic grant_log[$];
  exp_t ea, eb;
  int   cyc = 0;
  int   we_cnt = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;

  dmem_ctrl #(.BITS_ADDR(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_size(a_size), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_err(a_err), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      a_gcyc.delete();
      b_gcyc.delete();
    end else begin
      if (mem_we) we_cnt++;
      if (a_gnt) begin a_gcyc.push_back(cyc); grant_log.push_back(1'b0); end
      if (b_gnt) begin b_gcyc.push_back(cyc); grant_log.push_back(1'b1); end
      if (a_rvalid) begin
        if (a_exp.size() == 0 || a_gcyc.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL a_unexpected_rvalid actual=1 required=0 cycle=%0d", cyc);
        end else begin
          ea = a_exp.pop_front();
          check("a_rdata", a_rdata, ea.rd);
          check("a_err", {31'd0, a_err}, {31'd0, ea.err});
          check("a_latency", cyc - a_gcyc.pop_front(), ea.lat);
        end
      end else if (a_err) begin
        n_checks++; n_fail++;
        $display("FAIL a_err_without_rvalid actual=1 required=0 cycle=%0d", cyc);
      end
      if (b_rvalid) begin
        if (b_exp.size() == 0 || b_gcyc.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL b_unexpected_rvalid actual=1 required=0 cycle=%0d", cyc);
        end else begin
          eb = b_exp.pop_front();
          check("b_rdata", b_rdata, eb.rd);
          check("b_latency", cyc - b_gcyc.pop_front(), eb.lat);
        end
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while ((a_exp.size() != 0 || b_exp.size() != 0) && n < 50) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (a_exp.size() != 0 || b_exp.size() != 0) begin
      n_checks++; n_fail++;
      $display("FAIL completion_timeout actual=%0d required=0 pending", a_exp.size() + b_exp.size());
      a_exp.delete();
      b_exp.delete();
    end
  endtask

  task automatic wait_a_gnt();
    int n = 0;
    @(negedge clk);
    while (!a_gnt && n < 50) begin @(negedge clk); n++; end
    if (!a_gnt) begin
      n_checks++; n_fail++;
      $display("FAIL a_gnt_timeout actual=0 required=1");
    end
  endtask

  task automatic a_txn(input logic we, input logic [7:0] addr, input logic [1:0] size,
                       input logic [31:0] wd, input logic [31:0] exp_rd,
                       input logic exp_err, input int lat);
    a_exp.push_back('{rd: exp_rd, err: exp_err, lat: lat});
    @(posedge clk); #1;
    a_req = 1; a_we = we; a_addr = addr; a_size = size; a_wdata = wd;
    wait_a_gnt();
    @(posedge clk); #1;
    a_req = 0; a_we = 0;
    wait_idle();
  endtask

  task automatic b_txn(input logic we, input logic [7:0] addr, input logic [31:0] wd,
                       input logic [31:0] exp_rd);
    int n = 0;
    b_exp.push_back('{rd: exp_rd, err: 1'b0, lat: 2});
    @(posedge clk); #1;
    b_req = 1; b_we = we; b_addr = addr; b_wdata = wd;
    @(negedge clk);
    while (!b_gnt && n < 50) begin @(negedge clk); n++; end
    if (!b_gnt) begin
      n_checks++; n_fail++;
      $display("FAIL b_gnt_timeout actual=0 required=1");
    end
    @(posedge clk); #1;
    b_req = 0; b_we = 0;
    wait_idle();
  endtask

  initial begin
    int wc;
    int n;
    // Reset state with both requests asserted
    a_req = 1; b_req = 1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_a_gnt", {31'd0, a_gnt}, 32'd0);
    check("rst_b_gnt", {31'd0, b_gnt}, 32'd0);
    check("rst_a_rvalid", {31'd0, a_rvalid}, 32'd0);
    check("rst_mem_we", {31'd0, mem_we}, 32'd0);
    check("rst_mem_addr", {26'd0, mem_addr}, 32'd0);
    check("rst_a_rdata", a_rdata, 32'd0);
    a_req = 0; b_req = 0;
    rst_n = 1;

    a_txn(1, 8'h10, 2'b10, 32'h1122_3344, 32'h0, 0, 2);
    a_txn(0, 8'h10, 2'b10, 32'h0, 32'h1122_3344, 0, 2);
    a_txn(1, 8'h12, 2'b00, 32'h0000_00AA, 32'h0, 0, 3);
    check("mem_word4_after_byte_wr", mem[4], 32'h1122_AA44);
    a_txn(0, 8'h12, 2'b00, 32'h0, 32'h0000_00AA, 0, 2);
    a_txn(0, 8'h10, 2'b00, 32'h0, 32'h0000_0011, 0, 2);
    a_txn(0, 8'h13, 2'b00, 32'h0, 32'h0000_0044, 0, 2);
    a_txn(0, 8'h10, 2'b01, 32'h0, 32'h0000_1122, 0, 2);
    a_txn(0, 8'h12, 2'b01, 32'h0, 32'h0000_AA44, 0, 2);
    a_txn(1, 8'h16, 2'b01, 32'hFFFF_5566, 32'h0, 0, 3);
    b_txn(0, 8'h17, 32'h0, 32'h0000_5566);
    b_txn(1, 8'h22, 32'hCAFE_F00D, 32'h0);
    a_txn(0, 8'h20, 2'b10, 32'h0, 32'hCAFE_F00D, 0, 2);
    a_txn(1, 8'h21, 2'b00, 32'h1234_5677, 32'h0, 0, 3);
    a_txn(0, 8'h20, 2'b10, 32'h0, 32'hCA77_F00D, 0, 2);

    // Illegal accesses: one-cycle error completion, no memory write
    wc = we_cnt;
    a_txn(0, 8'h11, 2'b01, 32'h0, 32'h0, 1, 1);
    a_txn(1, 8'h22, 2'b10, 32'h0, 32'h0, 1, 1);
    a_txn(0, 8'h20, 2'b11, 32'h0, 32'h0, 1, 1);
    check("err_no_mem_we", we_cnt, wc);
    a_txn(0, 8'h20, 2'b10, 32'h0, 32'hCA77_F00D, 0, 2);

    // Reset in MERGE_WR aborts a halfword store
    @(posedge clk); #1;
    a_req = 1; a_we = 1; a_addr = 8'h10; a_size = 2'b01; a_wdata = 32'h0000_BEEF;
    wait_a_gnt();
    @(posedge clk); #1;
    a_req = 0; a_we = 0;
    @(posedge clk); #1;
    check("merge_mem_we", {31'd0, mem_we}, 32'd1);
    rst_n = 0; a_req = 1;
    #1;
    check("abort_mem_we", {31'd0, mem_we}, 32'd0);
    check("abort_a_gnt", {31'd0, a_gnt}, 32'd0);
    check("abort_mem_addr", {26'd0, mem_addr}, 32'd0);
    check("abort_a_rdata", a_rdata, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("abort_mem_word4", mem[4], 32'h1122_AA44);
    a_req = 0;
    rst_n = 1;
    repeat (4) @(posedge clk);

    // Continuous requests on both ports alternate starting with A
    grant_log.delete();
    repeat (2) begin
      a_exp.push_back('{rd: 32'hCA77_F00D, err: 1'b0, lat: 2});
      b_exp.push_back('{rd: 32'hCA77_F00D, err: 1'b0, lat: 2});
    end
    @(posedge clk); #1;
    a_req = 1; a_we = 0; a_size = 2'b10; a_addr = 8'h20;
    b_req = 1; b_we = 0; b_addr = 8'h20;
    n = 0;
    while (grant_log.size() < 3 && n < 50) begin @(posedge clk); n++; end
    #1 a_req = 0;
    n = 0;
    while (grant_log.size() < 4 && n < 50) begin @(posedge clk); n++; end
    #1 b_req = 0;
    wait_idle();
    check("arb_grant_count", grant_log.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < grant_log.size()) check($sformatf("arb_grant%0d_is_b", i), {31'd0, grant_log[i]}, i % 2);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=timeout required=finish");
    $fatal(1, "timeout");
  end

endmodule
